// File: rtl/rej_sample_ntt_pkg.sv
// Shared ML-KEM types and constants for the SampleNTT rejection-sampling parser.
// Holds modulus, polynomial size, SHAKE128 rate and the parser state encoding.
package types_kem;

  localparam int ML_KEM_Q            = 3329;
  localparam int ML_KEM_N            = 256;
  localparam int SHAKE128_RATE_BYTES = 168;

  localparam int TRIPLES = SHAKE128_RATE_BYTES / 3;
  localparam int CNT_W   = $clog2(ML_KEM_N) + 1;
  localparam int TRI_W   = $clog2(TRIPLES);

  typedef logic [11:0]                        coef_t;
  typedef coef_t [ML_KEM_N-1:0]               poly_t;
  typedef logic [8*SHAKE128_RATE_BYTES-1:0]   rate_blk_t;
  typedef logic [TRIPLES-1:0][23:0]           blk_triples_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_PARSE    = 2'd2
  } state_t;

  localparam coef_t            Q_COEF   = coef_t'(ML_KEM_Q);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(ML_KEM_N);
  localparam logic [TRI_W-1:0] TRI_LAST = TRI_W'(TRIPLES - 1);

  function automatic logic coef_below_q(input coef_t c);
    return c < Q_COEF;
  endfunction

endpackage

// File: rtl/rej_sample_ntt_if.sv
// Bus between the XOF / matrix sampler and the SampleNTT parser.
// Block handshake: a block transfers on a rising edge where blk_valid_i && blk_ready_o;
// blk_i must be stable while blk_valid_i is high, and blk_valid_i is ignored while blk_ready_o is low.
interface rej_sample_ntt_if;
  import types_kem::*;

  logic             start_i;
  rate_blk_t        blk_i;
  logic             blk_valid_i;
  logic             blk_ready_o;
  logic             squeeze_o;
  logic             busy_o;
  logic             done_o;
  poly_t            poly_o;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport slave (
    input  start_i, blk_i, blk_valid_i,
    output blk_ready_o, squeeze_o, busy_o, done_o, poly_o, dbg_state, dbg_cnt
  );

  modport master (
    output start_i, blk_i, blk_valid_i,
    input  blk_ready_o, squeeze_o, busy_o, done_o, poly_o, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/rej_sample_ntt_rej_triple.sv
// Splits one 3-byte group into two 12-bit candidates and flags which are below Q.
// Byte 0 sits in triple[7:0], byte 2 in triple[23:16].
module rej_triple
  import types_kem::*;
(
  input  logic [23:0] triple,
  output coef_t       d1,
  output coef_t       d2,
  output logic        acc1,
  output logic        acc2
);

  // d1 = b0 | b1[3:0]<<8, d2 = b1[7:4] | b2<<4 fall out as the low and high halves
  assign d1   = triple[11:0];
  assign d2   = triple[23:12];
  assign acc1 = coef_below_q(d1);
  assign acc2 = coef_below_q(d2);

endmodule

// File: rtl/rej_sample_ntt.sv
// SampleNTT parser: consumes SHAKE128 squeeze blocks, keeps 12-bit candidates below Q
// and assembles one NTT-domain polynomial, requesting more blocks until it is full.
module rej_sample_ntt
  import types_kem::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  rej_sample_ntt_if.slave   bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TRI_W-1:0] tri_idx, tri_nxt;
  rate_blk_t        blk_q;
  poly_t            poly_q;
  logic             done_q, done_nxt;
  logic             squeeze;
  logic             blk_take;

  blk_triples_t     blk_tri;
  logic [23:0]      triple;
  coef_t            d1, d2;
  logic             acc1, acc2;
  logic             w1, w2;
  logic [CNT_W-1:0] cnt_after1, cnt_new;

  assign blk_tri = blk_triples_t'(blk_q);
  assign triple  = blk_tri[tri_idx];

  rej_triple u_rej_triple (
    .triple (triple),
    .d1     (d1),
    .d2     (d2),
    .acc1   (acc1),
    .acc2   (acc2)
  );

  // d2 only lands if the slot after d1 (or d1's slot when d1 was rejected) still exists
  assign w1         = acc1 && (cnt < N_CNT);
  assign cnt_after1 = cnt + CNT_W'(w1);
  assign w2         = acc2 && (cnt_after1 < N_CNT);
  assign cnt_new    = cnt_after1 + CNT_W'(w2);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tri_nxt   = tri_idx;
    done_nxt  = 1'b0;
    squeeze   = 1'b0;
    blk_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_nxt = ST_WAIT_BLK;
          cnt_nxt   = '0;
          squeeze   = 1'b1;
        end
      end
      ST_WAIT_BLK: begin
        if (bus.blk_valid_i) begin
          blk_take  = 1'b1;
          tri_nxt   = '0;
          state_nxt = ST_PARSE;
        end
      end
      ST_PARSE: begin
        cnt_nxt = cnt_new;
        if (cnt_new == N_CNT) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (tri_idx == TRI_LAST) begin
          state_nxt = ST_WAIT_BLK;
          squeeze   = 1'b1;
        end else begin
          tri_nxt = tri_idx + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tri_idx <= '0;
      done_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tri_idx <= tri_nxt;
      done_q  <= done_nxt;
      if (blk_take) blk_q <= bus.blk_i;
    end
  end

  // Entries are overwritten in place; a new polynomial never clears the old one first
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      poly_q <= '0;
    end else if (state == ST_PARSE) begin
      if (w1) poly_q[cnt[CNT_W-2:0]]        <= d1;
      if (w2) poly_q[cnt_after1[CNT_W-2:0]] <= d2;
    end
  end

  assign bus.blk_ready_o = (state == ST_WAIT_BLK);
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.squeeze_o   = squeeze;
  assign bus.done_o      = done_q;
  assign bus.poly_o      = poly_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_cnt     = cnt;

endmodule
